// File: rtl/temp_sample_filter.sv
// temp_sample_filter: moving-average filter for a 12-bit signed temperature
// stream (0.0625 C/LSB) with a valid/ready handshake on both sides.
// Optional over-temperature alarm with hysteresis is built only when the
// macro TEMP_FILTER_ALARM_EN is defined; otherwise alarm is tied low.
//
// state   | meaning
// S_IDLE  | waiting for a sample, in_ready = enable
// S_ACCUM | update buffer, running sum, average and alarm (one cycle)
// S_OUT   | present out_data until out_ready
module temp_sample_filter #(
    parameter int                 AVG_LOG2 = 2,
    parameter logic signed [11:0] ALARM_HI = 12'sd480,
    parameter logic signed [11:0] ALARM_LO = 12'sd440
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        alarm
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 12 + AVG_LOG2;

    if (AVG_LOG2 < 1 || AVG_LOG2 > 4 || ALARM_LO >= ALARM_HI) begin : g_param_check
        $error("temp_sample_filter: illegal AVG_LOG2 or alarm thresholds");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    state_t               state_q, state_d;
    logic signed [11:0]   sample_q, sample_d;
    logic signed [11:0]   buf_q [DEPTH];
    logic signed [11:0]   buf_d [DEPTH];
    logic [AVG_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic                 primed_q, primed_d;
    logic [11:0]          avg_q, avg_d;

    logic signed [SW-1:0] sample_ext, oldest_ext, sum_next;
    logic signed [11:0]   avg_new;
    logic                 unused_low_bits;

    assign unused_low_bits = ^in_data[3:0];

    // New running sum and average; the first sample after priming fills the window
    always_comb begin
        sample_ext = {{AVG_LOG2{sample_q[11]}}, sample_q};
        oldest_ext = {{AVG_LOG2{buf_q[wr_ptr_q][11]}}, buf_q[wr_ptr_q]};
        if (primed_q) begin
            sum_next = sum_q - oldest_ext + sample_ext;
        end else begin
            sum_next = sample_ext <<< AVG_LOG2;
        end
        avg_new = 12'(sum_next >>> AVG_LOG2);
    end

    // Next-state and datapath update for the three-state handshake FSM
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        sum_d    = sum_q;
        primed_d = primed_q;
        avg_d    = avg_q;
        if (!enable) begin
            state_d  = S_IDLE;
            primed_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sample_d = in_data[15:4];
                        state_d  = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (primed_q) begin
                        buf_d[wr_ptr_q] = sample_q;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            buf_d[i] = sample_q;
                        end
                    end
                    wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
                    sum_d    = sum_next;
                    avg_d    = avg_new;
                    primed_d = 1'b1;
                    state_d  = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            sum_q    <= '0;
            primed_q <= 1'b0;
            avg_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            sum_q    <= sum_d;
            primed_q <= primed_d;
            avg_q    <= avg_d;
        end
    end

    // in_ready is forced low while reset is asserted even if enable is high
    assign in_ready  = rst_n && enable && (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = {avg_q, 4'b0000};

`ifdef TEMP_FILTER_ALARM_EN
    logic alarm_q, alarm_d;

    // Hysteresis on each new average: set above ALARM_HI, clear below ALARM_LO
    always_comb begin
        alarm_d = alarm_q;
        if (enable && state_q == S_ACCUM) begin
            if (avg_new > ALARM_HI) begin
                alarm_d = 1'b1;
            end else if (avg_new < ALARM_LO) begin
                alarm_d = 1'b0;
            end
        end
    end

    // Alarm register, holds while the block is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sample_filter.sv
// Directed bench for temp_sample_filter (AVG_LOG2 = 2, thresholds 480/440).
module tb_temp_sample_filter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        alarm;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef TEMP_FILTER_ALARM_EN
    localparam bit ALARM_BUILT = 1'b1;
`else
    localparam bit ALARM_BUILT = 1'b0;
`endif

    temp_sample_filter #(
        .AVG_LOG2(2),
        .ALARM_HI(12'sd480),
        .ALARM_LO(12'sd440)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    // Full transaction: handshake, measure latency, capture and accept output.
    task automatic run_sample(input logic [15:0] d, output logic [15:0] got, output int lat);
        int n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Handshake one sample and wait for out_valid without accepting it.
    task automatic start_and_wait(input logic [15:0] d, output bit ok);
        int n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic drop_enable();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_prime();
        logic [15:0] got;
        int lat;
        run_sample(16'h1900, got, lat);
        n_cmp++; if (got !== 16'h1900) begin n_bad++; $display("FAIL prime_data got=%h exp=1900", got); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL prime_latency got=%0d exp=2", lat); end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL prime_alarm got=%b exp=0", alarm); end
    endtask

    // Window continues from the primed 400: 400,400,800 -> 500; 240 -> 460; 280 -> 430
    task automatic test_average_alarm();
        logic [15:0] vin [5]  = '{16'h1900, 16'h1900, 16'h3200, 16'h0F00, 16'h1180};
        logic [15:0] vexp [5] = '{16'h1900, 16'h1900, 16'h1F40, 16'h1CC0, 16'h1AE0};
        logic        aexp [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] got;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_sample(vin[i], got, lat);
            n_cmp++; if (got !== vexp[i]) begin n_bad++; $display("FAIL avg_data[%0d] got=%h exp=%h", i, got, vexp[i]); end
            n_cmp++; if (alarm !== (aexp[i] & ALARM_BUILT)) begin n_bad++; $display("FAIL avg_alarm[%0d] got=%b exp=%b", i, alarm, aexp[i] & ALARM_BUILT); end
        end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL avg_latency got=%0d exp=2", lat); end
    endtask

    // -16 primed, -32 -> -80/4 = -20; -15 -> -79/4 floors to -20
    task automatic test_negative();
        logic [15:0] vin [3]  = '{16'hFF00, 16'hFE00, 16'hFF10};
        logic [15:0] vexp [3] = '{16'hFF00, 16'hFEC0, 16'hFEC0};
        logic [15:0] got;
        int lat;
        drop_enable();
        for (int i = 0; i < 3; i++) begin
            run_sample(vin[i], got, lat);
            n_cmp++; if (got !== vexp[i]) begin n_bad++; $display("FAIL neg_data[%0d] got=%h exp=%h", i, got, vexp[i]); end
        end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL neg_alarm got=%b exp=0", alarm); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        drop_enable();
        @(negedge clk);
        in_data  = 16'h1900;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_data = 16'h3200;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (out_data !== 16'h1900) begin n_bad++; $display("FAIL bp_first_data got=%h exp=1900", out_data); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid); end
            n_cmp++; if (out_data !== 16'h1900) begin n_bad++; $display("FAIL bp_data[%0d] got=%h exp=1900", c, out_data); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (out_data !== 16'h1F40) begin n_bad++; $display("FAIL bp_held_data got=%h exp=1F40", out_data); end
        n_cmp++; if (alarm !== ALARM_BUILT) begin n_bad++; $display("FAIL bp_alarm got=%b exp=%b", alarm, ALARM_BUILT); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Window 400,400,800,400 -> 500 held in S_OUT, then enable drops
    task automatic test_enable_drop();
        bit ok;
        logic [15:0] got;
        int lat;
        start_and_wait(16'h1900, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL en_wait_valid got=%b exp=1", ok); end
        n_cmp++; if (out_data !== 16'h1F40) begin n_bad++; $display("FAIL en_data got=%h exp=1F40", out_data); end
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL en_drop_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL en_drop_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (alarm !== ALARM_BUILT) begin n_bad++; $display("FAIL en_drop_alarm_hold got=%b exp=%b", alarm, ALARM_BUILT); end
        @(negedge clk);
        enable = 1'b1;
        run_sample(16'h0A00, got, lat);
        n_cmp++; if (got !== 16'h0A00) begin n_bad++; $display("FAIL en_reprime got=%h exp=0A00", got); end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL en_reprime_alarm got=%b exp=0", alarm); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [15:0] got;
        int lat;
        start_and_wait(16'h3200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_wait_valid got=%b exp=1", ok); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_data got=%h exp=0000", out_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        run_sample(16'h0640, got, lat);
        n_cmp++; if (got !== 16'h0640) begin n_bad++; $display("FAIL rst_reprime got=%h exp=0640", got); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rst_reprime_latency got=%0d exp=2", lat); end
    endtask

    // out_ready in idle is ignored; window 100,100,100,400 -> 175
    task automatic test_idle_out_ready();
        logic [15:0] got;
        int lat;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ready_valid[%0d] got=%b exp=0", c, out_valid); end
        end
        out_ready = 1'b0;
        run_sample(16'h1900, got, lat);
        n_cmp++; if (got !== 16'h0AF0) begin n_bad++; $display("FAIL idle_ready_data got=%h exp=0AF0", got); end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_average_alarm();
        test_negative();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_idle_out_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
